// File: rtl/kbd_ctrl_pkg.sv
// Shared definitions for the PS/2 keyboard controller: FSM encoding, prefix
// byte values and the press-counter wrap limit.
package kbd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } kbd_state_e;

  localparam logic [7:0] KB_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] KB_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] BCD_WRAP      = 8'h99;

endpackage

// File: rtl/kbd_ctrl_scancode_ascii.sv
// Combinational scan-code set 2 to ASCII lookup. Extended codes and any code
// without a printable/control mapping return 0x00.
module scancode_ascii (
  input  logic [7:0] code,
  input  logic       ext,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
        8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
        8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
        8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
        8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
        8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
        8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
        8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
        8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
        8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
        8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
        8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
        8'h46: ascii = 8'h39;
        8'h29: ascii = 8'h20; 8'h5A: ascii = 8'h0D; 8'h66: ascii = 8'h08;
        8'h0D: ascii = 8'h09; 8'h76: ascii = 8'h1B;
        default: ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/kbd_ctrl.sv
// Keyboard receive-FIFO consumer: pops one scan-code byte per three cycles,
// tracks make/break/extended prefixes and reports the held key.
module kbd_ctrl
  import kbd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic [7:0] key_ascii,
  output logic [7:0] press_bcd,
  output logic       err
);

  kbd_state_e state, state_nxt;
  logic       brk, ext, key_ext;
  logic       capture, same_key;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == BCD_WRAP)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (kb_ready) state_nxt = POP;
      POP:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign kb_nextdata_n = (state != POP);
  assign capture       = (state == IDLE) && kb_ready;
  // A byte names the held key only if the extended qualifier also matches.
  assign same_key      = key_valid && (kb_data == key_code) && (ext == key_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      brk       <= 1'b0;
      ext       <= 1'b0;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 8'h00;
      press_bcd <= 8'h00;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (kb_overflow)
        err <= 1'b1;
      if (capture) begin
        if (kb_data == KB_PREFIX_EXT) begin
          ext <= 1'b1;
        end else if (kb_data == KB_PREFIX_BRK) begin
          brk <= 1'b1;
        end else if (brk) begin
          if (same_key)
            key_valid <= 1'b0;
          brk <= 1'b0;
          ext <= 1'b0;
        end else begin
          // Typematic repeats of the held key are not new presses.
          if (!same_key) begin
            key_code  <= kb_data;
            key_ext   <= ext;
            key_valid <= 1'b1;
            press_bcd <= bcd_inc(press_bcd);
          end
          ext <= 1'b0;
        end
      end
    end
  end

  scancode_ascii u_ascii (
    .code  (key_code),
    .ext   (key_ext),
    .ascii (key_ascii)
  );

endmodule
